// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: PC, IF/ID and ID/EX pipeline registers of the RV32I core.
// Obeys stall/flush controls, forwards EX operands, feeds back E indices.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stallF, stallD             hold PC / hold IF/ID
//   flushD, flushE             bubble IF/ID / bubble ID/EX
//   PCSrcE, PCTargetE          redirect resolved in EX
//   InstrF -> InstrD, PCD, PCPlus4D, validD, PCF
//   CtrlD, RD1D, RD2D, ImmExtD, RS1D, RS2D, RdD -> E registers
//   ForwardAE/BE, ALUResultM, ResultW -> SrcAE, WriteDataE (combinational)
module pipe_stage_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CTRL_W    = 10,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              flushE,
    input  logic              PCSrcE,
    input  logic [31:0]       PCTargetE,
    input  logic [31:0]       InstrF,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCD,
    output logic [31:0]       PCPlus4D,
    output logic              validD,
    output logic              validE,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       ImmExtD,
    input  logic [4:0]        RS1D,
    input  logic [4:0]        RS2D,
    input  logic [4:0]        RdD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [4:0]        RS1E,
    output logic [4:0]        RS2E,
    output logic [4:0]        RDE,
    output logic              ResultSrcE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E,
    output logic [31:0]       ImmExtE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       ResultW,
    output logic [31:0]       SrcAE,
    output logic [31:0]       WriteDataE
);

    logic [31:0]       pcf_d, pcf_q;
    logic [31:0]       instrd_d, instrd_q;
    logic [31:0]       pcd_d, pcd_q;
    logic [31:0]       pc4d_d, pc4d_q;
    logic              validd_d, validd_q;

    logic [CTRL_W-1:0] ctrle_d, ctrle_q;
    logic [31:0]       rd1e_d, rd1e_q;
    logic [31:0]       rd2e_d, rd2e_q;
    logic [31:0]       imme_d, imme_q;
    logic [31:0]       pce_d, pce_q;
    logic [31:0]       pc4e_d, pc4e_q;
    logic [4:0]        rs1e_d, rs1e_q;
    logic [4:0]        rs2e_d, rs2e_q;
    logic [4:0]        rde_d, rde_q;
    logic              valide_d, valide_q;

    logic [31:0]       pcf_plus4;

    assign pcf_plus4 = pcf_q + 32'd4;

    // A redirect must win over a fetch stall, or a taken branch in EX
    // would be lost while a load-use stall is in progress.
    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE) begin
            pcf_d = PCTargetE;
        end else if (!stallF) begin
            pcf_d = pcf_plus4;
        end
    end

    always_comb begin
        instrd_d = instrd_q;
        pcd_d    = pcd_q;
        pc4d_d   = pc4d_q;
        validd_d = validd_q;
        if (flushD) begin
            instrd_d = NOP_INSTR;
            pcd_d    = '0;
            pc4d_d   = '0;
            validd_d = 1'b0;
        end else if (!stallD) begin
            instrd_d = InstrF;
            pcd_d    = pcf_q;
            pc4d_d   = pcf_plus4;
            validd_d = 1'b1;
        end
    end

    // E has no stall: it either loads or bubbles.  A bubble zeroes the
    // control bundle so RegWrite/ResultSrc cannot trigger forwarding or
    // a spurious load-use stall.
    always_comb begin
        ctrle_d  = CtrlD;
        rd1e_d   = RD1D;
        rd2e_d   = RD2D;
        imme_d   = ImmExtD;
        pce_d    = pcd_q;
        pc4e_d   = pc4d_q;
        rs1e_d   = RS1D;
        rs2e_d   = RS2D;
        rde_d    = RdD;
        valide_d = validd_q;
        if (flushE) begin
            ctrle_d  = '0;
            rd1e_d   = '0;
            rd2e_d   = '0;
            imme_d   = '0;
            pce_d    = '0;
            pc4e_d   = '0;
            rs1e_d   = '0;
            rs2e_d   = '0;
            rde_d    = '0;
            valide_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q    <= RESET_PC;
            instrd_q <= NOP_INSTR;
            pcd_q    <= '0;
            pc4d_q   <= '0;
            validd_q <= 1'b0;
            ctrle_q  <= '0;
            rd1e_q   <= '0;
            rd2e_q   <= '0;
            imme_q   <= '0;
            pce_q    <= '0;
            pc4e_q   <= '0;
            rs1e_q   <= '0;
            rs2e_q   <= '0;
            rde_q    <= '0;
            valide_q <= 1'b0;
        end else begin
            pcf_q    <= pcf_d;
            instrd_q <= instrd_d;
            pcd_q    <= pcd_d;
            pc4d_q   <= pc4d_d;
            validd_q <= validd_d;
            ctrle_q  <= ctrle_d;
            rd1e_q   <= rd1e_d;
            rd2e_q   <= rd2e_d;
            imme_q   <= imme_d;
            pce_q    <= pce_d;
            pc4e_q   <= pc4e_d;
            rs1e_q   <= rs1e_d;
            rs2e_q   <= rs2e_d;
            rde_q    <= rde_d;
            valide_q <= valide_d;
        end
    end

    // Select 11 is illegal; it yields zero so the operand is never X.
    always_comb begin
        unique case (ForwardAE)
            2'b00:   SrcAE = rd1e_q;
            2'b01:   SrcAE = ResultW;
            2'b10:   SrcAE = ALUResultM;
            default: SrcAE = '0;
        endcase
    end

    always_comb begin
        unique case (ForwardBE)
            2'b00:   WriteDataE = rd2e_q;
            2'b01:   WriteDataE = ResultW;
            2'b10:   WriteDataE = ALUResultM;
            default: WriteDataE = '0;
        endcase
    end

    assign PCF        = pcf_q;
    assign InstrD     = instrd_q;
    assign PCD        = pcd_q;
    assign PCPlus4D   = pc4d_q;
    assign validD     = validd_q;
    assign validE     = valide_q;
    assign CtrlE      = ctrle_q;
    assign RS1E       = rs1e_q;
    assign RS2E       = rs2e_q;
    assign RDE        = rde_q;
    assign ResultSrcE = ctrle_q[0];
    assign PCE        = pce_q;
    assign PCPlus4E   = pc4e_q;
    assign ImmExtE    = imme_q;

endmodule
